// File: rtl/axi_pkg.sv
// ---------------------------------------------------------------------------
// axi_pkg
// Shared AXI4 definitions for the router-port RAM slice: burst and response
// codes, FSM state types, and helpers that describe how the packed channel
// buses are laid out (field offsets and total widths).
//
// Packed channel layouts (LSB first):
//   AW/AR : ADDR | BURST[1:0] | SIZE[2:0] | LEN[7:0] | ID
//   W     : LAST | STRB | DATA
//   B     : ID | RESP[1:0]
//   R     : ID | LAST | RESP[1:0] | DATA
// ---------------------------------------------------------------------------
package axi_pkg;

   localparam logic [1:0] BURST_FIXED = 2'b00;
   localparam logic [1:0] BURST_INCR  = 2'b01;
   localparam logic [1:0] BURST_WRAP  = 2'b10;
   localparam logic [1:0] BURST_RSVD  = 2'b11;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {
      W_IDLE = 2'd0,
      W_DATA = 2'd1,
      W_RESP = 2'd2
   } w_state_e;

   typedef enum logic [1:0] {
      R_IDLE = 2'd0,
      R_READ = 2'd1,
      R_DATA = 2'd2
   } r_state_e;

   // Total widths of the packed channel buses.
   function automatic int ax_width(input int id_w, input int addr_w);
      return id_w + addr_w + 13;
   endfunction

   function automatic int w_width(input int data_w);
      return data_w + data_w / 8 + 1;
   endfunction

   function automatic int b_width(input int id_w);
      return id_w + 2;
   endfunction

   function automatic int r_width(input int id_w, input int data_w);
      return id_w + data_w + 3;
   endfunction

   // Field offsets inside an AW/AR bus; ADDR always starts at bit 0.
   function automatic int ax_burst_ofs(input int addr_w);
      return addr_w;
   endfunction

   function automatic int ax_size_ofs(input int addr_w);
      return addr_w + 2;
   endfunction

   function automatic int ax_len_ofs(input int addr_w);
      return addr_w + 5;
   endfunction

   function automatic int ax_id_ofs(input int addr_w);
      return addr_w + 13;
   endfunction

   // Only these lengths give a power-of-two wrap window.
   function automatic logic wrap_len_legal(input logic [7:0] len);
      return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
   endfunction

   // Address-phase legality: reserved burst type, beat wider than the bus,
   // or a wrap burst whose length cannot form a wrap window.
   function automatic logic ax_illegal(input logic [1:0] burst,
                                       input logic [2:0] size,
                                       input logic [7:0] len,
                                       input logic [2:0] max_size);
      return (burst == BURST_RSVD) || (size > max_size) ||
             ((burst == BURST_WRAP) && !wrap_len_legal(len));
   endfunction

endpackage

// File: rtl/axi_burst_addr_gen.sv
// ---------------------------------------------------------------------------
// axi_burst_addr_gen
// Combinational next-beat byte address for an AXI4 burst.
//
// Ports:
//   addr_i      current byte address
//   size_i      beat size code (bytes per beat = 1 << size_i)
//   len_i       burst length minus one (sets the wrap window)
//   burst_i     burst type (FIXED / INCR / WRAP / reserved)
//   next_addr_o address of the following beat, modulo 2^ADDR_W
// ---------------------------------------------------------------------------
module axi_burst_addr_gen
   import axi_pkg::*;
#(
   parameter int ADDR_W = 8
) (
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [2:0]        size_i,
   input  logic [7:0]        len_i,
   input  logic [1:0]        burst_i,
   output logic [ADDR_W-1:0] next_addr_o
);

   logic [ADDR_W-1:0] incr;
   logic [ADDR_W-1:0] incr_addr;
   logic [ADDR_W-1:0] wrap_mask;

   // A wrap burst keeps the bits above the window fixed and lets the
   // in-window offset roll over; illegal wrap lengths and the reserved
   // encoding fall back to a plain increment.
   always_comb begin
      incr      = ADDR_W'(1) << size_i;
      incr_addr = addr_i + incr;
      wrap_mask = ((ADDR_W'(len_i) + ADDR_W'(1)) << size_i) - ADDR_W'(1);
      case (burst_i)
         BURST_FIXED: next_addr_o = addr_i;
         BURST_WRAP: begin
            if (wrap_len_legal(len_i)) begin
               next_addr_o = (addr_i & ~wrap_mask) | (incr_addr & wrap_mask);
            end else begin
               next_addr_o = incr_addr;
            end
         end
         default: next_addr_o = incr_addr;
      endcase
   end

endmodule

// File: rtl/axi_port_ram.sv
// ---------------------------------------------------------------------------
// axi_port_ram
// AXI4 burst slave RAM sitting on one slave port of the master router. The
// write and read sides are independent FSMs sharing a one-write/one-read
// word memory, each handling a single outstanding burst.
//
// Ports:
//   ACLK, ARESET               clock, synchronous active-high reset
//   S_AXI_AWCH_i / VALID/READY packed write address channel
//   S_AXI_WCH_i  / VALID/READY packed write data channel
//   S_AXI_BCH_o  / VALID/READY packed write response channel
//   S_AXI_ARCH_i / VALID/READY packed read address channel
//   S_AXI_RCH_o  / VALID/READY packed read data channel
//
// Build option AXI_RAM_SLVERR_EN: when defined, illegal bursts (reserved
// burst type, oversize beats, bad wrap length, or a WLAST that disagrees with
// the beat count) are answered with SLVERR; bad write beats are dropped and
// bad read bursts return zero data. When undefined every burst is OKAY.
//
// Memory contents are deliberately not reset.
// ---------------------------------------------------------------------------
module axi_port_ram
   import axi_pkg::*;
#(
   parameter int AXI_ID_WIDTH   = 1,
   parameter int AXI_DATA_WIDTH = 32,
   parameter int AXI_ADDR_WIDTH = 8,
   parameter int MEM_WORDS      = 64
) (
   input  logic                                              ACLK,
   input  logic                                              ARESET,
   input  logic [ax_width(AXI_ID_WIDTH, AXI_ADDR_WIDTH)-1:0] S_AXI_AWCH_i,
   input  logic                                              S_AXI_AWCH_VALID_i,
   output logic                                              S_AXI_AWCH_READY_o,
   input  logic [w_width(AXI_DATA_WIDTH)-1:0]                S_AXI_WCH_i,
   input  logic                                              S_AXI_WCH_VALID_i,
   output logic                                              S_AXI_WCH_READY_o,
   output logic [b_width(AXI_ID_WIDTH)-1:0]                  S_AXI_BCH_o,
   output logic                                              S_AXI_BCH_VALID_o,
   input  logic                                              S_AXI_BCH_READY_i,
   input  logic [ax_width(AXI_ID_WIDTH, AXI_ADDR_WIDTH)-1:0] S_AXI_ARCH_i,
   input  logic                                              S_AXI_ARCH_VALID_i,
   output logic                                              S_AXI_ARCH_READY_o,
   output logic [r_width(AXI_ID_WIDTH, AXI_DATA_WIDTH)-1:0]  S_AXI_RCH_o,
   output logic                                              S_AXI_RCH_VALID_o,
   input  logic                                              S_AXI_RCH_READY_i
);

   localparam int BYTES    = AXI_DATA_WIDTH / 8;
   localparam int ADDR_LSB = $clog2(BYTES);
   localparam int IDX_W    = $clog2(MEM_WORDS);

   // ---------------- channel field decode ----------------
   logic [AXI_ADDR_WIDTH-1:0] aw_addr,  ar_addr;
   logic [1:0]                aw_burst, ar_burst;
   logic [2:0]                aw_size,  ar_size;
   logic [7:0]                aw_len,   ar_len;
   logic [AXI_ID_WIDTH-1:0]   aw_id,    ar_id;
   logic                      w_last;
   logic [BYTES-1:0]          w_strb;
   logic [AXI_DATA_WIDTH-1:0] w_data;

   assign aw_addr  = S_AXI_AWCH_i[AXI_ADDR_WIDTH-1:0];
   assign aw_burst = S_AXI_AWCH_i[ax_burst_ofs(AXI_ADDR_WIDTH) +: 2];
   assign aw_size  = S_AXI_AWCH_i[ax_size_ofs(AXI_ADDR_WIDTH) +: 3];
   assign aw_len   = S_AXI_AWCH_i[ax_len_ofs(AXI_ADDR_WIDTH) +: 8];
   assign aw_id    = S_AXI_AWCH_i[ax_id_ofs(AXI_ADDR_WIDTH) +: AXI_ID_WIDTH];

   assign ar_addr  = S_AXI_ARCH_i[AXI_ADDR_WIDTH-1:0];
   assign ar_burst = S_AXI_ARCH_i[ax_burst_ofs(AXI_ADDR_WIDTH) +: 2];
   assign ar_size  = S_AXI_ARCH_i[ax_size_ofs(AXI_ADDR_WIDTH) +: 3];
   assign ar_len   = S_AXI_ARCH_i[ax_len_ofs(AXI_ADDR_WIDTH) +: 8];
   assign ar_id    = S_AXI_ARCH_i[ax_id_ofs(AXI_ADDR_WIDTH) +: AXI_ID_WIDTH];

   assign w_last   = S_AXI_WCH_i[0];
   assign w_strb   = S_AXI_WCH_i[1 +: BYTES];
   assign w_data   = S_AXI_WCH_i[BYTES+1 +: AXI_DATA_WIDTH];

   // ---------------- write side state ----------------
   w_state_e                  w_state_q, w_state_d;
   logic [AXI_ID_WIDTH-1:0]   w_id_q,    w_id_d;
   logic [7:0]                w_len_q,   w_len_d;
   logic [2:0]                w_size_q,  w_size_d;
   logic [1:0]                w_burst_q, w_burst_d;
   logic [AXI_ADDR_WIDTH-1:0] w_addr_q,  w_addr_d;
   logic [7:0]                w_cnt_q,   w_cnt_d;
   logic                      w_err_q,   w_err_d;
   logic                      awready_q, awready_d;
   logic                      wready_q,  wready_d;
   logic                      bvalid_q,  bvalid_d;
   logic [1:0]                bresp_q,   bresp_d;

   // ---------------- read side state ----------------
   r_state_e                  r_state_q, r_state_d;
   logic [AXI_ID_WIDTH-1:0]   r_id_q,    r_id_d;
   logic [7:0]                r_len_q,   r_len_d;
   logic [2:0]                r_size_q,  r_size_d;
   logic [1:0]                r_burst_q, r_burst_d;
   logic [AXI_ADDR_WIDTH-1:0] r_addr_q,  r_addr_d;
   logic [7:0]                r_cnt_q,   r_cnt_d;
   logic                      r_err_q,   r_err_d;
   logic                      arready_q, arready_d;
   logic                      rvalid_q,  rvalid_d;
   logic                      rlast_q,   rlast_d;
   logic [1:0]                rresp_q,   rresp_d;
   logic [AXI_DATA_WIDTH-1:0] rdata_q,   rdata_d;

   logic [AXI_ADDR_WIDTH-1:0] w_addr_next, r_addr_next;
   logic                      aw_fire, w_fire, b_fire, ar_fire, r_fire;
   logic                      w_last_beat;
   logic                      aw_err, ar_err, beat_err;
   logic                      mem_we;
   logic [IDX_W-1:0]          w_idx, r_idx;

   logic [AXI_DATA_WIDTH-1:0] mem [MEM_WORDS];

   assign aw_fire     = S_AXI_AWCH_VALID_i & awready_q;
   assign w_fire      = S_AXI_WCH_VALID_i  & wready_q;
   assign b_fire      = bvalid_q & S_AXI_BCH_READY_i;
   assign ar_fire     = S_AXI_ARCH_VALID_i & arready_q;
   assign r_fire      = rvalid_q & S_AXI_RCH_READY_i;
   assign w_last_beat = (w_cnt_q == w_len_q);

   // Upper address bits beyond the memory depth are ignored, so large
   // addresses alias onto the same words.
   assign w_idx = w_addr_q[ADDR_LSB +: IDX_W];
   assign r_idx = r_addr_q[ADDR_LSB +: IDX_W];

`ifdef AXI_RAM_SLVERR_EN
   localparam logic [2:0] MAX_SIZE = 3'(ADDR_LSB);
   assign aw_err   = ax_illegal(aw_burst, aw_size, aw_len, MAX_SIZE);
   assign ar_err   = ax_illegal(ar_burst, ar_size, ar_len, MAX_SIZE);
   assign beat_err = (w_last != w_last_beat);
`else
   logic unused_w_last;
   assign aw_err        = 1'b0;
   assign ar_err        = 1'b0;
   assign beat_err      = 1'b0;
   assign unused_w_last = w_last;
`endif

   // A beat is dropped once the burst is flagged bad (including the
   // offending beat itself), and nothing lands while reset is asserted.
   assign mem_we = w_fire & ~w_err_q & ~beat_err & ~ARESET;

   axi_burst_addr_gen #(.ADDR_W(AXI_ADDR_WIDTH)) u_w_addr_gen (
      .addr_i      (w_addr_q),
      .size_i      (w_size_q),
      .len_i       (w_len_q),
      .burst_i     (w_burst_q),
      .next_addr_o (w_addr_next)
   );

   axi_burst_addr_gen #(.ADDR_W(AXI_ADDR_WIDTH)) u_r_addr_gen (
      .addr_i      (r_addr_q),
      .size_i      (r_size_q),
      .len_i       (r_len_q),
      .burst_i     (r_burst_q),
      .next_addr_o (r_addr_next)
   );

   // Byte-lane write port; the read port samples in R_READ, so a read and a
   // write of the same word on one edge returns the old contents.
   always_ff @(posedge ACLK) begin
      if (mem_we) begin
         for (int b = 0; b < BYTES; b++) begin
            if (w_strb[b]) begin
               mem[w_idx][b*8 +: 8] <= w_data[b*8 +: 8];
            end
         end
      end
   end

   // Write FSM next state. Handshake outputs are decoded from the next state
   // so they are registered and line up with the state they belong to.
   // Termination is purely by beat count; WLAST only feeds error checking.
   always_comb begin
      w_state_d = w_state_q;
      w_id_d    = w_id_q;
      w_len_d   = w_len_q;
      w_size_d  = w_size_q;
      w_burst_d = w_burst_q;
      w_addr_d  = w_addr_q;
      w_cnt_d   = w_cnt_q;
      w_err_d   = w_err_q;
      awready_d = awready_q;
      wready_d  = wready_q;
      bvalid_d  = bvalid_q;
      bresp_d   = bresp_q;
      case (w_state_q)
         W_IDLE: begin
            awready_d = 1'b1;
            if (aw_fire) begin
               w_id_d    = aw_id;
               w_len_d   = aw_len;
               w_size_d  = aw_size;
               w_burst_d = aw_burst;
               w_addr_d  = aw_addr;
               w_cnt_d   = 8'd0;
               w_err_d   = aw_err;
               awready_d = 1'b0;
               wready_d  = 1'b1;
               w_state_d = W_DATA;
            end
         end
         W_DATA: begin
            if (w_fire) begin
               w_cnt_d  = w_cnt_q + 8'd1;
               w_addr_d = w_addr_next;
               w_err_d  = w_err_q | beat_err;
               if (w_last_beat) begin
                  wready_d  = 1'b0;
                  bvalid_d  = 1'b1;
                  bresp_d   = (w_err_q | beat_err) ? RESP_SLVERR : RESP_OKAY;
                  w_state_d = W_RESP;
               end
            end
         end
         W_RESP: begin
            if (b_fire) begin
               bvalid_d  = 1'b0;
               awready_d = 1'b1;
               w_state_d = W_IDLE;
            end
         end
         default: begin
            awready_d = 1'b0;
            wready_d  = 1'b0;
            bvalid_d  = 1'b0;
            w_state_d = W_IDLE;
         end
      endcase
   end

   // Write FSM registers; reset abandons any burst in flight.
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         w_state_q <= W_IDLE;
         w_id_q    <= '0;
         w_len_q   <= '0;
         w_size_q  <= '0;
         w_burst_q <= '0;
         w_addr_q  <= '0;
         w_cnt_q   <= '0;
         w_err_q   <= 1'b0;
         awready_q <= 1'b0;
         wready_q  <= 1'b0;
         bvalid_q  <= 1'b0;
         bresp_q   <= '0;
      end else begin
         w_state_q <= w_state_d;
         w_id_q    <= w_id_d;
         w_len_q   <= w_len_d;
         w_size_q  <= w_size_d;
         w_burst_q <= w_burst_d;
         w_addr_q  <= w_addr_d;
         w_cnt_q   <= w_cnt_d;
         w_err_q   <= w_err_d;
         awready_q <= awready_d;
         wready_q  <= wready_d;
         bvalid_q  <= bvalid_d;
         bresp_q   <= bresp_d;
      end
   end

   // Read FSM next state. Each beat costs a memory-read cycle (R_READ)
   // followed by a presentation cycle (R_DATA) held until RREADY.
   always_comb begin
      r_state_d = r_state_q;
      r_id_d    = r_id_q;
      r_len_d   = r_len_q;
      r_size_d  = r_size_q;
      r_burst_d = r_burst_q;
      r_addr_d  = r_addr_q;
      r_cnt_d   = r_cnt_q;
      r_err_d   = r_err_q;
      arready_d = arready_q;
      rvalid_d  = rvalid_q;
      rlast_d   = rlast_q;
      rresp_d   = rresp_q;
      rdata_d   = rdata_q;
      case (r_state_q)
         R_IDLE: begin
            arready_d = 1'b1;
            if (ar_fire) begin
               r_id_d    = ar_id;
               r_len_d   = ar_len;
               r_size_d  = ar_size;
               r_burst_d = ar_burst;
               r_addr_d  = ar_addr;
               r_cnt_d   = 8'd0;
               r_err_d   = ar_err;
               arready_d = 1'b0;
               r_state_d = R_READ;
            end
         end
         R_READ: begin
            rdata_d   = r_err_q ? '0 : mem[r_idx];
            rresp_d   = r_err_q ? RESP_SLVERR : RESP_OKAY;
            rlast_d   = (r_cnt_q == r_len_q);
            rvalid_d  = 1'b1;
            r_state_d = R_DATA;
         end
         R_DATA: begin
            if (r_fire) begin
               rvalid_d = 1'b0;
               if (rlast_q) begin
                  arready_d = 1'b1;
                  r_state_d = R_IDLE;
               end else begin
                  r_cnt_d   = r_cnt_q + 8'd1;
                  r_addr_d  = r_addr_next;
                  r_state_d = R_READ;
               end
            end
         end
         default: begin
            arready_d = 1'b0;
            rvalid_d  = 1'b0;
            r_state_d = R_IDLE;
         end
      endcase
   end

   // Read FSM registers, including the registered R payload.
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         r_state_q <= R_IDLE;
         r_id_q    <= '0;
         r_len_q   <= '0;
         r_size_q  <= '0;
         r_burst_q <= '0;
         r_addr_q  <= '0;
         r_cnt_q   <= '0;
         r_err_q   <= 1'b0;
         arready_q <= 1'b0;
         rvalid_q  <= 1'b0;
         rlast_q   <= 1'b0;
         rresp_q   <= '0;
         rdata_q   <= '0;
      end else begin
         r_state_q <= r_state_d;
         r_id_q    <= r_id_d;
         r_len_q   <= r_len_d;
         r_size_q  <= r_size_d;
         r_burst_q <= r_burst_d;
         r_addr_q  <= r_addr_d;
         r_cnt_q   <= r_cnt_d;
         r_err_q   <= r_err_d;
         arready_q <= arready_d;
         rvalid_q  <= rvalid_d;
         rlast_q   <= rlast_d;
         rresp_q   <= rresp_d;
         rdata_q   <= rdata_d;
      end
   end

   assign S_AXI_AWCH_READY_o = awready_q;
   assign S_AXI_WCH_READY_o  = wready_q;
   assign S_AXI_BCH_VALID_o  = bvalid_q;
   assign S_AXI_BCH_o        = {bresp_q, w_id_q};
   assign S_AXI_ARCH_READY_o = arready_q;
   assign S_AXI_RCH_VALID_o  = rvalid_q;
   assign S_AXI_RCH_o        = {rdata_q, rresp_q, rlast_q, r_id_q};

endmodule

// File: tb/tb_axi_port_ram.sv
// ---------------------------------------------------------------------------
// tb_axi_port_ram
// Directed bench for axi_port_ram. Stimulus tasks queue the expected B and R
// responses; a monitor pops and compares them as the DUT hands them over.
// ---------------------------------------------------------------------------
module tb_axi_port_ram;
   import axi_pkg::*;

   localparam int AW_W = 22;
   localparam int W_W  = 37;
   localparam int B_W  = 3;
   localparam int R_W  = 36;

   typedef struct {
      logic       id;
      logic [1:0] resp;
   } b_exp_t;

   typedef struct {
      logic [31:0] data;
      logic [1:0]  resp;
      logic        last;
      logic        id;
   } r_exp_t;

   logic            aclk;
   logic            areset;
   logic [AW_W-1:0] aw_ch;
   logic            aw_valid, aw_ready;
   logic [W_W-1:0]  w_ch;
   logic            w_valid, w_ready;
   logic [B_W-1:0]  b_ch;
   logic            b_valid, b_ready;
   logic [AW_W-1:0] ar_ch;
   logic            ar_valid, ar_ready;
   logic [R_W-1:0]  r_ch;
   logic            r_valid, r_ready;

   int              n_checks = 0;
   int              n_errors = 0;
   b_exp_t          exp_b[$];
   r_exp_t          exp_r[$];
   logic [31:0]     wdata_tbl [16];
   logic [3:0]      wstrb_tbl [16];
   logic [31:0]     rdata_tbl [16];

   axi_port_ram dut (
      .ACLK               (aclk),
      .ARESET             (areset),
      .S_AXI_AWCH_i       (aw_ch),
      .S_AXI_AWCH_VALID_i (aw_valid),
      .S_AXI_AWCH_READY_o (aw_ready),
      .S_AXI_WCH_i        (w_ch),
      .S_AXI_WCH_VALID_i  (w_valid),
      .S_AXI_WCH_READY_o  (w_ready),
      .S_AXI_BCH_o        (b_ch),
      .S_AXI_BCH_VALID_o  (b_valid),
      .S_AXI_BCH_READY_i  (b_ready),
      .S_AXI_ARCH_i       (ar_ch),
      .S_AXI_ARCH_VALID_i (ar_valid),
      .S_AXI_ARCH_READY_o (ar_ready),
      .S_AXI_RCH_o        (r_ch),
      .S_AXI_RCH_VALID_o  (r_valid),
      .S_AXI_RCH_READY_i  (r_ready)
   );

   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   task automatic checkOutput(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_errors++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Inputs change 1 time unit after the rising edge.
   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   task automatic send_aw(input logic id, input logic [7:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst);
      int n = 0;
      aw_ch    = {id, len, size, burst, addr};
      aw_valid = 1'b1;
      while (!aw_ready && n < 50) begin
         tick();
         n++;
      end
      if (!aw_ready) checkOutput("aw_handshake", aw_ready, 1);
      tick();
      aw_valid = 1'b0;
   endtask

   task automatic send_ar(input logic id, input logic [7:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst);
      int n = 0;
      ar_ch    = {id, len, size, burst, addr};
      ar_valid = 1'b1;
      while (!ar_ready && n < 50) begin
         tick();
         n++;
      end
      if (!ar_ready) checkOutput("ar_handshake", ar_ready, 1);
      tick();
      ar_valid = 1'b0;
   endtask

   task automatic send_w(input logic [31:0] data, input logic [3:0] strb, input logic last);
      int n = 0;
      w_ch    = {data, strb, last};
      w_valid = 1'b1;
      while (!w_ready && n < 50) begin
         tick();
         n++;
      end
      if (!w_ready) checkOutput("w_handshake", w_ready, 1);
      tick();
      w_valid = 1'b0;
   endtask

   // Full write burst from wdata_tbl/wstrb_tbl; BVALID must rise exactly
   // on the cycle after the final beat.
   task automatic applyStimulus(input logic id, input logic [7:0] addr, input logic [7:0] len,
                                input logic [2:0] size, input logic [1:0] burst,
                                input logic [1:0] resp);
      b_exp_t e;
      e.id   = id;
      e.resp = resp;
      exp_b.push_back(e);
      send_aw(id, addr, len, size, burst);
      for (int i = 0; i <= int'(len); i++) begin
         send_w(wdata_tbl[i], wstrb_tbl[i], (i == int'(len)));
         checkOutput("bvalid_timing", b_valid, (i == int'(len)));
      end
   endtask

   task automatic push_reads(input logic id, input logic [7:0] len, input logic [1:0] resp);
      r_exp_t e;
      for (int i = 0; i <= int'(len); i++) begin
         e.data = rdata_tbl[i];
         e.resp = resp;
         e.last = (i == int'(len));
         e.id   = id;
         exp_r.push_back(e);
      end
   endtask

   task automatic wait_drain();
      int n = 0;
      while ((exp_b.size() != 0 || exp_r.size() != 0) && n < 200) begin
         tick();
         n++;
      end
      if (exp_b.size() != 0 || exp_r.size() != 0)
         checkOutput("drain_timeout", exp_b.size() + exp_r.size(), 0);
      tick();
   endtask

   // Monitor: a VALID&READY pair seen on the falling edge is the transfer
   // taken at the next rising edge.
   initial begin
      b_exp_t eb;
      r_exp_t er;
      forever begin
         @(negedge aclk);
         if (b_valid && b_ready) begin
            if (exp_b.size() == 0) begin
               checkOutput("b_unexpected", exp_b.size(), 1);
            end else begin
               eb = exp_b.pop_front();
               checkOutput("b_id", b_ch[0], eb.id);
               checkOutput("b_resp", b_ch[2:1], eb.resp);
            end
         end
         if (r_valid && r_ready) begin
            if (exp_r.size() == 0) begin
               checkOutput("r_unexpected", exp_r.size(), 1);
            end else begin
               er = exp_r.pop_front();
               checkOutput("r_data", r_ch[35:4], er.data);
               checkOutput("r_resp", r_ch[3:2], er.resp);
               checkOutput("r_last", r_ch[1], er.last);
               checkOutput("r_id", r_ch[0], er.id);
            end
         end
      end
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", n_errors);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      areset   = 1'b1;
      aw_ch    = '0;
      aw_valid = 1'b0;
      w_ch     = '0;
      w_valid  = 1'b0;
      b_ready  = 1'b1;
      ar_ch    = '0;
      ar_valid = 1'b0;
      r_ready  = 1'b1;

      // Reset state
      repeat (3) tick();
      checkOutput("rst_awready", aw_ready, 0);
      checkOutput("rst_wready", w_ready, 0);
      checkOutput("rst_bvalid", b_valid, 0);
      checkOutput("rst_arready", ar_ready, 0);
      checkOutput("rst_rvalid", r_valid, 0);
      checkOutput("rst_bch", b_ch, 0);
      checkOutput("rst_rch", r_ch, 0);
      areset = 1'b0;
      tick();
      checkOutput("rel_awready", aw_ready, 1);
      checkOutput("rel_arready", ar_ready, 1);

      // Test 1: INCR write of A0..A3 to words 4..7
      $display("[TB] test 1: INCR write burst");
      for (int i = 0; i < 4; i++) begin
         wdata_tbl[i] = 32'hA0 + 32'(i);
         wstrb_tbl[i] = 4'hF;
      end
      applyStimulus(1'b1, 8'h10, 8'd3, 3'd2, BURST_INCR, RESP_OKAY);
      wait_drain();

      // Test 2: read back with latency and back-pressure checks
      $display("[TB] test 2: INCR read with RREADY stall");
      r_ready = 1'b0;
      for (int i = 0; i < 4; i++) rdata_tbl[i] = 32'hA0 + 32'(i);
      push_reads(1'b0, 8'd3, RESP_OKAY);
      send_ar(1'b0, 8'h10, 8'd3, 3'd2, BURST_INCR);
      checkOutput("r_latency_c1", r_valid, 0);
      tick();
      checkOutput("r_latency_c2", r_valid, 1);
      for (int i = 0; i < 3; i++) begin
         tick();
         checkOutput("r_hold_valid", r_valid, 1);
         checkOutput("r_hold_data", r_ch[35:4], 32'hA0);
      end
      r_ready = 1'b1;
      wait_drain();

      // Test 3a: WRAP write lands on words 6,7,4,5
      $display("[TB] test 3: WRAP and FIXED bursts");
      for (int i = 0; i < 4; i++) begin
         wdata_tbl[i] = 32'(i + 1);
         wstrb_tbl[i] = 4'hF;
      end
      applyStimulus(1'b0, 8'h18, 8'd3, 3'd2, BURST_WRAP, RESP_OKAY);
      wait_drain();
      rdata_tbl[0] = 32'd3; rdata_tbl[1] = 32'd4; rdata_tbl[2] = 32'd1; rdata_tbl[3] = 32'd2;
      push_reads(1'b1, 8'd3, RESP_OKAY);
      send_ar(1'b1, 8'h10, 8'd3, 3'd2, BURST_INCR);
      wait_drain();
      rdata_tbl[0] = 32'd1; rdata_tbl[1] = 32'd2; rdata_tbl[2] = 32'd3; rdata_tbl[3] = 32'd4;
      push_reads(1'b0, 8'd3, RESP_OKAY);
      send_ar(1'b0, 8'h18, 8'd3, 3'd2, BURST_WRAP);
      wait_drain();

      // Test 3b: FIXED burst merges three byte lanes into word 8
      wdata_tbl[0] = 32'hFFFF_FFFF; wstrb_tbl[0] = 4'hF;
      applyStimulus(1'b0, 8'h20, 8'd0, 3'd2, BURST_INCR, RESP_OKAY);
      wait_drain();
      wdata_tbl[0] = 32'h1111_1111; wstrb_tbl[0] = 4'h1;
      wdata_tbl[1] = 32'h2222_2222; wstrb_tbl[1] = 4'h2;
      wdata_tbl[2] = 32'h3333_3333; wstrb_tbl[2] = 4'h4;
      applyStimulus(1'b1, 8'h20, 8'd2, 3'd2, BURST_FIXED, RESP_OKAY);
      wait_drain();
      rdata_tbl[0] = 32'hFF33_2211;
      push_reads(1'b0, 8'd0, RESP_OKAY);
      send_ar(1'b0, 8'h20, 8'd0, 3'd2, BURST_INCR);
      wait_drain();

      // Test 4: write and read of word 0 on the same edge
      $display("[TB] test 4: concurrent read/write of one word");
      wdata_tbl[0] = 32'h1234_5678; wstrb_tbl[0] = 4'hF;
      applyStimulus(1'b0, 8'h00, 8'd0, 3'd2, BURST_INCR, RESP_OKAY);
      wait_drain();
      begin
         b_exp_t eb;
         eb.id   = 1'b1;
         eb.resp = RESP_OKAY;
         exp_b.push_back(eb);
      end
      rdata_tbl[0] = 32'h1234_5678;
      push_reads(1'b0, 8'd0, RESP_OKAY);
      send_aw(1'b1, 8'h00, 8'd0, 3'd2, BURST_INCR);
      send_ar(1'b0, 8'h00, 8'd0, 3'd2, BURST_INCR);
      send_w(32'hCAFE_F00D, 4'hF, 1'b1);
      wait_drain();
      rdata_tbl[0] = 32'hCAFE_F00D;
      push_reads(1'b1, 8'd0, RESP_OKAY);
      send_ar(1'b1, 8'h00, 8'd0, 3'd2, BURST_INCR);
      wait_drain();

      // Test 5: reset after the second of four beats
      $display("[TB] test 5: reset mid write burst");
      for (int i = 0; i < 4; i++) begin
         wdata_tbl[i] = 32'hE0 + 32'(i);
         wstrb_tbl[i] = 4'hF;
      end
      applyStimulus(1'b0, 8'h30, 8'd3, 3'd2, BURST_INCR, RESP_OKAY);
      wait_drain();
      send_aw(1'b1, 8'h30, 8'd3, 3'd2, BURST_INCR);
      send_w(32'h51, 4'hF, 1'b0);
      send_w(32'h52, 4'hF, 1'b0);
      areset = 1'b1;
      tick();
      checkOutput("mid_rst_awready", aw_ready, 0);
      checkOutput("mid_rst_wready", w_ready, 0);
      checkOutput("mid_rst_bvalid", b_valid, 0);
      checkOutput("mid_rst_arready", ar_ready, 0);
      checkOutput("mid_rst_rvalid", r_valid, 0);
      areset = 1'b0;
      tick();
      checkOutput("post_rst_awready", aw_ready, 1);
      checkOutput("post_rst_wready", w_ready, 0);
      repeat (3) tick();
      checkOutput("post_rst_no_b", b_valid, 0);
      rdata_tbl[0] = 32'h51; rdata_tbl[1] = 32'h52; rdata_tbl[2] = 32'hE2; rdata_tbl[3] = 32'hE3;
      push_reads(1'b0, 8'd3, RESP_OKAY);
      send_ar(1'b0, 8'h30, 8'd3, 3'd2, BURST_INCR);
      wait_drain();

`ifdef AXI_RAM_SLVERR_EN
      // Test 6: reserved burst write and oversize read answer SLVERR
      $display("[TB] test 6: SLVERR handling");
      wdata_tbl[0] = 32'h600D_0010; wstrb_tbl[0] = 4'hF;
      wdata_tbl[1] = 32'h600D_0011; wstrb_tbl[1] = 4'hF;
      applyStimulus(1'b0, 8'h40, 8'd1, 3'd2, BURST_INCR, RESP_OKAY);
      wait_drain();
      wdata_tbl[0] = 32'hBAD0_0000; wdata_tbl[1] = 32'hBAD0_0001;
      applyStimulus(1'b1, 8'h40, 8'd1, 3'd2, BURST_RSVD, RESP_SLVERR);
      wait_drain();
      rdata_tbl[0] = 32'h600D_0010; rdata_tbl[1] = 32'h600D_0011;
      push_reads(1'b0, 8'd1, RESP_OKAY);
      send_ar(1'b0, 8'h40, 8'd1, 3'd2, BURST_INCR);
      wait_drain();
      rdata_tbl[0] = 32'h0;
      push_reads(1'b1, 8'd0, RESP_SLVERR);
      send_ar(1'b1, 8'h40, 8'd0, 3'd3, BURST_INCR);
      wait_drain();
`endif

      repeat (2) tick();
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
